// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control block: state encoding and
// default / reduced timing constants.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } sw_state_t;

  // Board timing at CLOCK_50: 1 s tick, 20 ms key debounce.
  localparam int TICK_DIV_DEF     = 50_000_000;
  localparam int DEBOUNCE_CYC_DEF = 1_000_000;

  // Reduced values so simulation reaches interesting behaviour quickly.
  localparam int SIM_TICK_DIV     = 10;
  localparam int SIM_DEBOUNCE_CYC = 4;

endpackage

// File: rtl/stopwatch_ctrl_key_debounce.sv
// Push-button conditioning: 2-FF synchronizer, stable-level debounce and a
// one-cycle press pulse on the accepted released->pressed transition.
module key_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic CLOCK_50,
  input  logic RESET,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          sync1, sync2;
  logic [1:0]    fill;
  logic          stable, stable_d;
  logic          armed;
  logic [CW-1:0] db_cnt;

  // Synchronize the raw key; fill marks when sync2 carries a real sample
  // rather than the reset preset.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      fill  <= 2'b00;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      fill  <= {fill[0], 1'b1};
    end
  end

  // Accept a new level only after DEBOUNCE_CYC consecutive mismatched cycles.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      stable <= 1'b1;
      db_cnt <= '0;
    end else if (sync2 == stable) begin
      db_cnt <= '0;
    end else if (db_cnt == CW'(DEBOUNCE_CYC - 1)) begin
      stable <= sync2;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + CW'(1);
    end
  end

  // Registered falling-edge pulse. A key already held through reset is
  // accepted silently; presses count only once the key was seen released.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      stable_d <= 1'b1;
      armed    <= 1'b0;
      press    <= 1'b0;
    end else begin
      stable_d <= stable;
      armed    <= armed | (fill[1] & sync2);
      press    <= armed & stable_d & ~stable;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: key events, run/pause/lap/clear FSM and 1 Hz prescaler
// driving the mm:ss counter and display hold.
//
//   state | meaning
//   IDLE  | stopped, counter holds last value (or cleared)
//   RUN   | counting, display live
//   PAUSE | counting suspended, prescaler phase kept
//   LAP   | counting, display frozen
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV     = TICK_DIV_DEF,
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       KEY0,
  input  logic       KEY1,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       disp_hold,
  output logic       run_led,
  output logic [1:0] state
);

  localparam int PW = $clog2(TICK_DIV);

  logic          press0, press1;
  logic          ss, lr;
  sw_state_t     cur, nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic          en_nxt, clr_nxt;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key0 (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .key_n    (KEY0),
    .press    (press0)
  );

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key1 (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .key_n    (KEY1),
    .press    (press1)
  );

  // Start/stop has priority; a simultaneous lap/clear press is dropped.
  assign ss = press0;
  assign lr = press1 & ~press0;

  // Next state, prescaler and output pulses. The tick is based on the
  // current state so a wrap coinciding with a stop is still delivered.
  always_comb begin
    nxt       = cur;
    presc_nxt = presc;
    en_nxt    = 1'b0;
    clr_nxt   = 1'b0;
    if (cur == RUN || cur == LAP) begin
      if (presc == PW'(TICK_DIV - 1)) begin
        presc_nxt = '0;
        en_nxt    = 1'b1;
      end else begin
        presc_nxt = presc + PW'(1);
      end
    end
    case (cur)
      IDLE: begin
        if (ss) begin
          nxt       = RUN;
          presc_nxt = '0;
        end else if (lr) begin
          clr_nxt = 1'b1;
        end
      end
      RUN: begin
        if (ss)      nxt = PAUSE;
        else if (lr) nxt = LAP;
      end
      LAP: begin
        if (ss)      nxt = PAUSE;
        else if (lr) nxt = RUN;
      end
      PAUSE: begin
        if (ss) begin
          nxt = RUN;
        end else if (lr) begin
          nxt     = IDLE;
          clr_nxt = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // State, prescaler and registered outputs.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      cur       <= IDLE;
      presc     <= '0;
      cnt_en    <= 1'b0;
      cnt_clr   <= 1'b0;
      disp_hold <= 1'b0;
      run_led   <= 1'b0;
    end else begin
      cur       <= nxt;
      presc     <= presc_nxt;
      cnt_en    <= en_nxt;
      cnt_clr   <= clr_nxt;
      disp_hold <= (nxt == LAP);
      run_led   <= (nxt == RUN) || (nxt == LAP);
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios then random key activity,
// every cycle compared against a behavioural model of the stopwatch.
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  localparam int T  = SIM_TICK_DIV;
  localparam int D  = SIM_DEBOUNCE_CYC;
  localparam int HN = D + 2;

  logic       CLOCK_50 = 1'b0;
  logic       RESET, KEY0, KEY1;
  logic       cnt_en, cnt_clr, disp_hold, run_led;
  logic [1:0] state;

  int n_chk = 0;
  int n_err = 0;
  int seen_en, seen_clr;

  // Model: raw sample history per key, accepted level, and stopwatch state.
  bit         h[2][HN];
  bit         s[2], f[2], p[2], a[2];
  int         age;
  logic [1:0] m_st;
  int         m_pre;
  bit         m_en, m_clr;

  stopwatch_ctrl #(.TICK_DIV(T), .DEBOUNCE_CYC(D)) dut (
    .CLOCK_50  (CLOCK_50),
    .RESET     (RESET),
    .KEY0      (KEY0),
    .KEY1      (KEY1),
    .cnt_en    (cnt_en),
    .cnt_clr   (cnt_clr),
    .disp_hold (disp_hold),
    .run_led   (run_led),
    .state     (state)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < HN; i++) h[k][i] = 1'b1;
      s[k] = 1'b1; f[k] = 1'b0; p[k] = 1'b0; a[k] = 1'b0;
    end
    age   = 0;
    m_st  = IDLE;
    m_pre = 0;
    m_en  = 1'b0;
    m_clr = 1'b0;
  endtask

  // One clock edge of the model. A level is accepted once the raw key has
  // held it for D consecutive samples (seen 2 cycles late through the
  // synchronizer); the press pulse follows one cycle later, and only for a
  // key that has been seen released since reset.
  task automatic m_edge(input bit r0, input bit r1);
    bit raw[2];
    bit ss, lr, run, flip;
    if (RESET) begin
      m_reset();
      return;
    end
    raw[0] = r0;
    raw[1] = r1;
    age++;
    ss = p[0];
    lr = p[1] && !p[0];
    for (int k = 0; k < 2; k++) begin
      p[k] = f[k] && a[k];
      for (int i = HN - 1; i > 0; i--) h[k][i] = h[k][i-1];
      h[k][0] = raw[k];
      if (age >= 3 && h[k][2]) a[k] = 1'b1;
      flip = 1'b1;
      for (int i = 2; i < D + 2; i++) if (h[k][i] == s[k]) flip = 1'b0;
      f[k] = flip && s[k];
      if (flip) s[k] = !s[k];
    end
    run   = (m_st == RUN) || (m_st == LAP);
    m_en  = 1'b0;
    m_clr = 1'b0;
    if (run) begin
      m_pre = m_pre + 1;
      if (m_pre == T) begin
        m_pre = 0;
        m_en  = 1'b1;
      end
    end
    if (ss) begin
      if (m_st == IDLE) begin
        m_st  = RUN;
        m_pre = 0;
      end else if (m_st == PAUSE) m_st = RUN;
      else m_st = PAUSE;
    end else if (lr) begin
      if (m_st == IDLE) m_clr = 1'b1;
      else if (m_st == RUN) m_st = LAP;
      else if (m_st == LAP) m_st = RUN;
      else begin
        m_st  = IDLE;
        m_clr = 1'b1;
      end
    end
  endtask

  task automatic cyc(input bit k0, input bit k1, input bit r);
    logic [5:0] exp_v;
    @(negedge CLOCK_50);
    KEY0  = k0;
    KEY1  = k1;
    RESET = r;
    @(posedge CLOCK_50);
    m_edge(k0, k1);
    #1;
    exp_v = {m_st, m_en, m_clr, (m_st == LAP), (m_st == RUN || m_st == LAP)};
    chk("cyc", {state, cnt_en, cnt_clr, disp_hold, run_led}, exp_v);
    if (cnt_en)  seen_en++;
    if (cnt_clr) seen_clr++;
  endtask

  // Press the selected keys (active-low) for 10 cycles, then release 10.
  task automatic tap(input bit p0, input bit p1);
    for (int i = 0; i < 20; i++) cyc(!(p0 && i < 10), !(p1 && i < 10), 1'b0);
  endtask

  initial begin
    int lat, t1, t2, trun, ten;
    bit k0, k1, r;
    RESET = 1'b1;
    KEY0  = 1'b0;
    KEY1  = 1'b1;
    m_reset();

    // Reset with KEY0 held, then keep holding: no event.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'b0);
    chk("held_idle", {state, cnt_en, cnt_clr, disp_hold, run_led}, 6'd0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b0);

    // Short glitch ignored.
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b0);
    chk("glitch_idle", state, IDLE);

    // Clean press: RUN 8 cycles after raw edge, ticks 10 and 20 later.
    lat = 0; t1 = 0; t2 = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc(i > 12, 1'b1, 1'b0);
      if (state == RUN && lat == 0) lat = i;
      if (cnt_en && t1 == 0) t1 = i;
      else if (cnt_en && t2 == 0) t2 = i;
    end
    chk("ss_lat", lat, 8);
    chk("tick1", t1, 18);
    chk("tick2", t2, 28);

    // Pause with prescaler held at 6, stay quiet, resume after 4 cycles.
    for (int i = 0; i < 20 && m_pre != 8; i++) cyc(1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 12; i++) cyc(i > 10, 1'b1, 1'b0);
    chk("pause_state", state, PAUSE);
    seen_en = 0;
    for (int i = 0; i < 50; i++) cyc(1'b1, 1'b1, 1'b0);
    chk("pause_quiet", seen_en, 0);
    trun = 0; ten = 0;
    for (int i = 1; i <= 30; i++) begin
      cyc(i > 10, 1'b1, 1'b0);
      if (state == RUN && trun == 0) trun = i;
      if (cnt_en && ten == 0) ten = i;
    end
    chk("resume_lat", ten - trun, 4);

    // Lap freeze keeps ticking, then back to RUN.
    tap(1'b0, 1'b1);
    chk("lap_hold", {state, disp_hold}, {LAP, 1'b1});
    seen_en = 0;
    for (int i = 0; i < 30; i++) cyc(1'b1, 1'b1, 1'b0);
    chk("lap_ticks", seen_en, 3);
    tap(1'b0, 1'b1);
    chk("lap_exit", {state, disp_hold}, {RUN, 1'b0});

    // Clear from PAUSE, then clear again from IDLE.
    tap(1'b1, 1'b0);
    seen_clr = 0;
    tap(1'b0, 1'b1);
    chk("clr_pause", {state, 6'(seen_clr)}, {IDLE, 6'd1});
    seen_clr = 0;
    tap(1'b0, 1'b1);
    chk("clr_idle", {state, 6'(seen_clr)}, {IDLE, 6'd1});

    // Both keys together in RUN: start/stop wins.
    tap(1'b1, 1'b0);
    seen_clr = 0;
    tap(1'b1, 1'b1);
    chk("both_keys", {state, disp_hold, 6'(seen_clr)}, {PAUSE, 1'b0, 6'd0});

    // Reset asserted asynchronously during LAP.
    tap(1'b1, 1'b0);
    tap(1'b0, 1'b1);
    chk("pre_rst_lap", state, LAP);
    RESET = 1'b1;
    #1;
    m_reset();
    chk("rst_async", {state, cnt_en, cnt_clr, disp_hold, run_led}, 6'd0);
    cyc(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b0);

    // Random key activity with occasional resets.
    k0 = 1'b1;
    k1 = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) k0 = !k0;
      if ($urandom_range(0, 9) == 0) k1 = !k1;
      r = ($urandom_range(0, 399) == 0);
      cyc(k0, k1, r);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control sequencer for the mm:ss stopwatch datapath (seconds/minutes counter, BCD split, 7-segment decoders).
- Debounces the two push-buttons, runs the run/pause/lap/clear state machine and owns the 1 Hz prescaler.
- Drives the counter's enable and clear, plus a display-hold flag for lap freeze.
- The counter and display logic consume only this block's outputs and have no key or prescaler logic of their own.

Parameters:
- TICK_DIV, 50_000_000: CLOCK_50 cycles per count tick; prescaler counts 0..TICK_DIV-1.
- DEBOUNCE_CYC, 1_000_000: consecutive stable synced cycles (20 ms) before a key level is accepted.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- RESET  in  1  asynchronous, active-high reset
- KEY0  in  1  raw push-button, active-low: start/stop
- KEY1  in  1  raw push-button, active-low: lap / clear
- cnt_en  out  1  one-cycle pulse: counter increments by one second
- cnt_clr  out  1  one-cycle pulse: counter clears to 00:00
- disp_hold  out  1  display shows latched value while 1
- run_led  out  1  high in RUN or LAP
- state  out  2  current FSM state, encoding as in package

Behaviour:
- Reset (async assert, release synchronous to CLOCK_50):
  - state=IDLE; cnt_en, cnt_clr, disp_hold, run_led = 0.
  - Prescaler = 0.
  - Debouncers preset to "released" (stable=1), so no event is generated at reset release even if a key is held.
- Key path, per key:
  - 2-FF synchronizer.
  - Debounce counter runs while synced != stable and clears otherwise. After DEBOUNCE_CYC consecutive mismatched cycles, stable takes the synced value.
  - Press event = registered 1->0 transition of stable; exactly one cycle wide.
  - Latency: raw edge (held clean) to event pulse = DEBOUNCE_CYC+3 cycles. Release generates no event.
  - Glitches shorter than DEBOUNCE_CYC cycles produce no event.
- Events: ss = KEY0 press, lr = KEY1 press. If both occur in the same cycle, ss wins and lr is discarded.
- FSM; all outputs registered, visible the cycle after the event:
  - IDLE(00):
    - ss -> RUN, prescaler cleared to 0.
    - lr -> stay IDLE, cnt_clr pulse.
  - RUN(01):
    - ss -> PAUSE.
    - lr -> LAP, disp_hold=1.
  - LAP(11): counting continues, display frozen.
    - lr -> RUN, disp_hold=0.
    - ss -> PAUSE, disp_hold=0.
  - PAUSE(10):
    - ss -> RUN; prescaler resumes from its held value and is NOT cleared.
    - lr -> IDLE, cnt_clr pulse.
- Prescaler:
  - Width $clog2(TICK_DIV).
  - Increments only in RUN/LAP; holds in PAUSE and IDLE.
  - At TICK_DIV-1 it wraps to 0 and cnt_en pulses for one cycle.
  - If a transition out of RUN/LAP occurs in the same cycle as the wrap, the tick is still issued. No tick is issued once the state is PAUSE/IDLE.
- cnt_en and cnt_clr are never high in the same cycle.
- RESET mid-debounce or mid-tick: all counters abort to 0 and no pending event survives.
- The mm:ss wrap at 59:59 is the counter's responsibility; this block never stops ticking.

Decomposition:
- Shared package stopwatch_pkg:
  - state encoding constants: IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, LAP=2'b11.
  - Default TICK_DIV and DEBOUNCE_CYC values.
  - Simulation overrides: TICK_DIV=10, DEBOUNCE_CYC=4.
- One sub-module key_debounce: sync + debounce + falling-edge pulse. Params DEBOUNCE_CYC. Ports CLOCK_50, RESET, key_n, press. Instanced twice.
- FSM and prescaler stay in stopwatch_ctrl.

Test Plan (TICK_DIV=10, DEBOUNCE_CYC=4):
- Reset with KEY0=0 held, then release RESET and hold 20 cycles -> no event; state=IDLE, all outputs 0.
- KEY0 low for 2 cycles, then high -> no event, state stays IDLE. KEY0 clean press -> ss pulse exactly 7 cycles after the raw edge; state=RUN the next cycle; first cnt_en 10 cycles after RUN entry, then every 10 cycles.
- In RUN, press KEY0 when prescaler=6 -> PAUSE, no cnt_en for 50 cycles. Press KEY0 again -> RUN; next cnt_en 4 cycles after re-entry (resume, not restart).
- In RUN, press KEY1 -> LAP, disp_hold=1, cnt_en keeps pulsing every 10. Press KEY1 -> RUN, disp_hold=0.
- PAUSE + KEY1 press -> single-cycle cnt_clr, state=IDLE. IDLE + KEY1 -> cnt_clr pulse, state stays IDLE.
- KEY0 and KEY1 pressed on the same raw cycle while in RUN -> PAUSE (ss wins), disp_hold=0, no cnt_clr. Assert RESET during LAP -> immediately IDLE, disp_hold=0.
